// File: rtl/sdram_cmd_sched.sv
// Single-bank SDRAM command sequencer: one request at a time, ACT -> RD/WR -> PRE,
// with spacing taken from the timing inputs latched at accept.
module sdram_cmd_sched #(
  parameter int ROW_W = 12,
  parameter int COL_W = 8
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   En,
  input  logic                   ReqValid,
  input  logic                   ReqWe,
  input  logic [ROW_W+COL_W-1:0] ReqAddr,
  output logic                   ReqReady,
  input  logic [7:0]             tpre,
  input  logic [7:0]             tcas,
  input  logic [3:0]             tlat,
  input  logic [7:0]             tburst,
  input  logic [7:0]             twait,
  output logic                   CS,
  output logic                   RAS,
  output logic                   CAS,
  output logic                   WeOut,
  output logic [ROW_W-1:0]       RowAddr,
  output logic [COL_W-1:0]       ColAddr,
  output logic                   BurstActive,
  output logic                   Busy,
  output logic                   Done,
  output logic [2:0]             StateOut
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACT   = 3'd1,
    S_TRCD  = 3'd2,
    S_CMD   = 3'd3,
    S_LAT   = 3'd4,
    S_BURST = 3'd5,
    S_PRE   = 3'd6,
    S_TRP   = 3'd7
  } state_e;

  state_e           state_q, state_d, succ;
  // Nine bits because the precharge phase spans tpre+twait, up to 510 cycles.
  logic [8:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             we_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic [7:0]       tpre_q, tcas_q, tburst_q, twait_q;
  logic [3:0]       tlat_q;
  logic             accept;
  logic [8:0]       trp_len;

  function automatic logic [7:0] clamp8(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

  assign trp_len = {1'b0, tpre_q} + {1'b0, twait_q};

  // Cycle count for the state being entered; single-cycle states load 1.
  function automatic logic [8:0] dur(input state_e s);
    case (s)
      S_TRCD:  return {1'b0, tcas_q} - 9'd1;
      S_LAT:   return {5'd0, tlat_q} - 9'd1;
      S_BURST: return {1'b0, tburst_q};
      S_TRP:   return trp_len - 9'd1;
      default: return 9'd1;
    endcase
  endfunction

  assign accept = (state_q == S_IDLE) && ReqValid && En;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    succ    = S_IDLE;
    case (state_q)
      S_IDLE:  succ = S_ACT;
      S_ACT:   succ = (tcas_q > 8'd1) ? S_TRCD : S_CMD;
      S_TRCD:  succ = S_CMD;
      S_CMD:   succ = (!we_q && tlat_q > 4'd1) ? S_LAT : S_BURST;
      S_LAT:   succ = S_BURST;
      S_BURST: succ = S_PRE;
      S_PRE:   succ = (trp_len > 9'd1) ? S_TRP : S_IDLE;
      default: succ = S_IDLE;
    endcase
    if (En) begin
      if (state_q == S_IDLE) begin
        if (ReqValid) state_d = S_ACT;
      end else if (cnt_q <= 9'd1) begin
        state_d = succ;
      end else begin
        cnt_d = cnt_q - 9'd1;
      end
      if (state_d != state_q) cnt_d = dur(state_d);
      done_d = (state_q != S_IDLE) && (state_d == S_IDLE);
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (Rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      tpre_q   <= 8'd1;
      tcas_q   <= 8'd1;
      tlat_q   <= 4'd1;
      tburst_q <= 8'd1;
      twait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (accept) begin
        we_q     <= ReqWe;
        row_q    <= ReqAddr[ROW_W+COL_W-1:COL_W];
        col_q    <= ReqAddr[COL_W-1:0];
        tpre_q   <= clamp8(tpre);
        tcas_q   <= clamp8(tcas);
        tlat_q   <= (tlat == 4'd0) ? 4'd1 : tlat;
        tburst_q <= clamp8(tburst);
        twait_q  <= twait;
      end
    end
  end

  always_comb begin
    {CS, RAS, CAS, WeOut} = 4'b1111;
    if (En) begin
      case (state_q)
        S_ACT:   {CS, RAS, CAS, WeOut} = 4'b0011;
        S_CMD:   {CS, RAS, CAS, WeOut} = {3'b010, ~we_q};
        S_PRE:   {CS, RAS, CAS, WeOut} = 4'b0010;
        default: {CS, RAS, CAS, WeOut} = 4'b1111;
      endcase
    end
  end

  assign ReqReady    = (state_q == S_IDLE);
  assign Busy        = ~ReqReady;
  assign BurstActive = En && (state_q == S_BURST);
  assign Done        = En && done_q && (state_q == S_IDLE);
  assign RowAddr     = row_q;
  assign ColAddr     = col_q;
  assign StateOut    = state_q;

endmodule
